// File: rtl/sync_pkg.sv
// sync_pkg: shared default widths and the queued pixel entry type for sync_pair_aligner
//   DEF_COORD_W/DEF_R_W/DEF_G_W/DEF_B_W : default field widths
//   ENTRY_W                             : packed width of one {x,y,r,g,b} entry
//   pix_entry_t                         : packed source pixel record, x in the MSBs
package sync_pkg;
  localparam int DEF_COORD_W = 10;
  localparam int DEF_R_W = 5;
  localparam int DEF_G_W = 6;
  localparam int DEF_B_W = 5;
  localparam int ENTRY_W = 2*DEF_COORD_W + DEF_R_W + DEF_G_W + DEF_B_W;
  typedef struct packed {
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
    logic [DEF_R_W-1:0]     r;
    logic [DEF_G_W-1:0]     g;
    logic [DEF_B_W-1:0]     b;
  } pix_entry_t;
endpackage

// File: rtl/sync_tag_fifo.sv
// sync_tag_fifo: in-order tag queue holding source pixels until their Homography return
//   clk_25, rst_n   : pixel clock, asynchronous active-low reset
//   i_flush         : synchronous clear of pointers and level
//   i_push, i_wdata : write one entry at the write pointer
//   i_pop           : retire the head entry
//   o_rdata         : head entry (combinational)
//   o_level         : occupancy; o_full/o_empty are derived from it alone
module sync_tag_fifo import sync_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int W = ENTRY_W,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          clk_25,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_level;
  always_ff @(posedge clk_25 or negedge rst_n)
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PW'(1);
      if (i_pop) r_rd <= r_rd + PW'(1);
      r_level <= r_level + LW'(i_push) - LW'(i_pop);
    end
  always_ff @(posedge clk_25)
    if (i_push) r_mem[r_wr] <= i_wdata;
  assign o_rdata = r_mem[r_rd];
  assign o_level = r_level;
  assign o_full = r_level == LW'(DEPTH);
  assign o_empty = r_level == '0;
endmodule

// File: rtl/sync_pair_aligner.sv
// sync_pair_aligner: pairs each source pixel with its in-order Homography return
//   clk_25, rst_n            : pixel clock, asynchronous active-low reset
//   in_valid/in_ready/in_*   : source pixel handshake and fields
//   flush, err_clr           : queue clear, sticky error clear
//   query_valid/query_x/y    : one-cycle query strobe, coordinates held between pushes
//   ret_valid/ret_*          : Homography result
//   out_valid/sync_*/dvi_*/ccd_* : paired output, fields held between pops
//   level                    : queue occupancy
//   err_underflow            : sticky, return seen with empty queue
//   err_mismatch             : sticky, echoed coordinates differ from head
//   Macro SYNC_COORD_CHECK_EN enables the echoed-coordinate comparator.
module sync_pair_aligner import sync_pkg::*; #(
  parameter int COORD_W = DEF_COORD_W,
  parameter int R_W = DEF_R_W,
  parameter int G_W = DEF_G_W,
  parameter int B_W = DEF_B_W,
  parameter int DEPTH = 8
) (
  input  logic                       clk_25,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [COORD_W-1:0]         in_x,
  input  logic [COORD_W-1:0]         in_y,
  input  logic [R_W-1:0]             in_r,
  input  logic [G_W-1:0]             in_g,
  input  logic [B_W-1:0]             in_b,
  input  logic                       flush,
  input  logic                       err_clr,
  output logic                       query_valid,
  output logic [COORD_W-1:0]         query_x,
  output logic [COORD_W-1:0]         query_y,
  input  logic                       ret_valid,
  input  logic [COORD_W-1:0]         ret_x,
  input  logic [COORD_W-1:0]         ret_y,
  input  logic [R_W-1:0]             ret_r,
  input  logic [G_W-1:0]             ret_g,
  input  logic [B_W-1:0]             ret_b,
  output logic                       out_valid,
  output logic [COORD_W-1:0]         sync_x,
  output logic [COORD_W-1:0]         sync_y,
  output logic [R_W-1:0]             dvi_r,
  output logic [G_W-1:0]             dvi_g,
  output logic [B_W-1:0]             dvi_b,
  output logic [R_W-1:0]             ccd_r,
  output logic [G_W-1:0]             ccd_g,
  output logic [B_W-1:0]             ccd_b,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err_underflow,
  output logic                       err_mismatch
);
  localparam int EW = 2*COORD_W + R_W + G_W + B_W;
  logic              w_push, w_pop, w_full, w_empty;
  logic [EW-1:0]     w_head;
  logic [COORD_W-1:0] w_hx, w_hy;
  logic [R_W-1:0]    w_hr;
  logic [G_W-1:0]    w_hg;
  logic [B_W-1:0]    w_hb;
  assign in_ready = !w_full;
  // flush swallows any same-cycle push or pop
  assign w_push = in_valid & in_ready & !flush;
  assign w_pop = ret_valid & !w_empty & !flush;
  assign {w_hx, w_hy, w_hr, w_hg, w_hb} = w_head;
  sync_tag_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk_25(clk_25),
    .rst_n(rst_n),
    .i_flush(flush),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_wdata({in_x, in_y, in_r, in_g, in_b}),
    .o_rdata(w_head),
    .o_level(level),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  always_ff @(posedge clk_25 or negedge rst_n)
    if (!rst_n) begin
      query_valid <= 1'b0;
      query_x <= '0;
      query_y <= '0;
      out_valid <= 1'b0;
      {sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b} <= '0;
      err_underflow <= 1'b0;
    end else begin
      query_valid <= w_push;
      if (w_push) {query_x, query_y} <= {in_x, in_y};
      out_valid <= w_pop;
      if (w_pop) {sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b} <=
        {w_head, ret_r, ret_g, ret_b};
      // a new error in the same cycle as err_clr keeps the flag set
      err_underflow <= (ret_valid & w_empty) | (err_underflow & !err_clr);
    end
`ifdef SYNC_COORD_CHECK_EN
  always_ff @(posedge clk_25 or negedge rst_n)
    if (!rst_n) err_mismatch <= 1'b0;
    else err_mismatch <= (w_pop & ((ret_x != w_hx) | (ret_y != w_hy))) | (err_mismatch & !err_clr);
`else
  logic w_unused;
  assign w_unused = ^{ret_x, ret_y, w_hx, w_hy};
  assign err_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_sync_pair_aligner.sv
// tb_sync_pair_aligner: directed table, corner sequences and random traffic against a queue model
module tb_sync_pair_aligner;
  localparam int DEPTH = 8;
`ifdef SYNC_COORD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } ent_t;
  typedef struct {
    logic iv;
    ent_t ie;
    logic rv;
    ent_t re;
    logic fl;
    logic ec;
    logic e_qv;
    logic e_ov;
    int   e_lvl;
    logic e_eu;
  } vec_t;

  logic clk_25 = 1'b0, rst_n;
  logic in_valid, in_ready, flush, err_clr, query_valid, ret_valid, out_valid;
  logic [9:0] in_x, in_y, query_x, query_y, ret_x, ret_y, sync_x, sync_y;
  logic [4:0] in_r, in_b, ret_r, ret_b, dvi_r, dvi_b, ccd_r, ccd_b;
  logic [5:0] in_g, ret_g, dvi_g, ccd_g;
  logic [3:0] level;
  logic err_underflow, err_mismatch;

  always #5 clk_25 = ~clk_25;

  sync_pair_aligner dut (
    .clk_25(clk_25), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .flush(flush), .err_clr(err_clr),
    .query_valid(query_valid), .query_x(query_x), .query_y(query_y),
    .ret_valid(ret_valid), .ret_x(ret_x), .ret_y(ret_y),
    .ret_r(ret_r), .ret_g(ret_g), .ret_b(ret_b),
    .out_valid(out_valid), .sync_x(sync_x), .sync_y(sync_y),
    .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b),
    .ccd_r(ccd_r), .ccd_g(ccd_g), .ccd_b(ccd_b),
    .level(level), .err_underflow(err_underflow), .err_mismatch(err_mismatch)
  );

  int n_vec = 0, n_bad = 0;
  ent_t m_q[$];
  logic m_qv, m_ov, m_eu, m_em;
  logic [9:0] m_qx, m_qy;
  ent_t m_sync, m_ccd;
  ent_t z = '0;
  vec_t tbl[10];

  function automatic ent_t mk(input int x, input int y, input int r, input int g, input int b);
    ent_t t;
    t.x = x[9:0];
    t.y = y[9:0];
    t.r = r[4:0];
    t.g = g[5:0];
    t.b = b[4:0];
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    {m_qv, m_ov, m_eu, m_em, m_qx, m_qy} = '0;
    m_sync = '0;
    m_ccd = '0;
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("query", 64'({query_valid, query_x, query_y}), 64'({m_qv, m_qx, m_qy}));
    chk("pair", 64'({sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b}),
        64'({m_sync, m_ccd.r, m_ccd.g, m_ccd.b}));
    chk("level", 64'(level), 64'(m_q.size()));
    chk("in_ready", 64'(in_ready), 64'(m_q.size() < DEPTH));
    chk("err_underflow", 64'(err_underflow), 64'(m_eu));
    chk("err_mismatch", 64'(err_mismatch), 64'(m_em));
  endtask

  task automatic step(input logic iv, input ent_t ie, input logic rv, input ent_t re,
                      input logic fl, input logic ec);
    int n;
    bit push, pop, und, mis;
    in_valid = iv;
    {in_x, in_y, in_r, in_g, in_b} = ie;
    ret_valid = rv;
    {ret_x, ret_y, ret_r, ret_g, ret_b} = re;
    flush = fl;
    err_clr = ec;
    n = m_q.size();
    push = iv && n < DEPTH && !fl;
    pop = rv && n > 0 && !fl;
    und = rv && n == 0;
    mis = CHK && pop && (re.x != m_q[0].x || re.y != m_q[0].y);
    m_qv = push;
    if (push) begin
      m_qx = ie.x;
      m_qy = ie.y;
    end
    m_ov = pop;
    if (pop) begin
      m_sync = m_q[0];
      m_ccd = re;
    end
    m_eu = und | (m_eu & !ec);
    m_em = mis | (m_em & !ec);
    if (fl) m_q.delete();
    else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(ie);
    end
    @(posedge clk_25);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    {in_valid, ret_valid, flush, err_clr} = '0;
    {in_x, in_y, in_r, in_g, in_b} = '0;
    {ret_x, ret_y, ret_r, ret_g, ret_b} = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk_25);
    #1;
    model_reset();
    check_all();
    rst_n = 1'b1;

    tbl[0] = '{1'b1, mk(5, 7, 3, 9, 1), 1'b0, z, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
    tbl[1] = '{1'b0, z, 1'b0, z, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
    tbl[2] = '{1'b0, z, 1'b1, mk(5, 7, 31, 63, 31), 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    tbl[3] = '{1'b0, z, 1'b1, z, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1};
    tbl[4] = '{1'b0, z, 1'b0, z, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    tbl[5] = '{1'b0, z, 1'b1, z, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1};
    tbl[6] = '{1'b0, z, 1'b0, z, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    tbl[7] = '{1'b1, mk(10, 20, 1, 2, 3), 1'b1, z, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1};
    tbl[8] = '{1'b0, z, 1'b0, z, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
    tbl[9] = '{1'b0, z, 1'b1, mk(10, 21, 4, 5, 6), 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].iv, tbl[i].ie, tbl[i].rv, tbl[i].re, tbl[i].fl, tbl[i].ec);
      chk("tbl_query_valid", 64'(query_valid), 64'(tbl[i].e_qv));
      chk("tbl_out_valid", 64'(out_valid), 64'(tbl[i].e_ov));
      chk("tbl_level", 64'(level), 64'(tbl[i].e_lvl));
      chk("tbl_err_underflow", 64'(err_underflow), 64'(tbl[i].e_eu));
      if (i == 0) chk("t2_query", 64'({query_x, query_y}), 64'({10'd5, 10'd7}));
      if (i == 2)
        chk("t2_pair", 64'({sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b}),
            64'({10'd5, 10'd7, 5'd3, 6'd9, 5'd1, 5'd31, 6'd63, 5'd31}));
    end
    chk("t5_mismatch", 64'(err_mismatch), 64'(CHK));
    chk("t5_sync", 64'({sync_x, sync_y}), 64'({10'd10, 10'd20}));
    step(1'b0, z, 1'b0, z, 1'b0, 1'b1);

    for (int k = 0; k < DEPTH; k++) step(1'b1, mk(k, k + 1, k, k, k), 1'b0, z, 1'b0, 1'b0);
    chk("full_level", 64'(level), 64'(8));
    chk("full_ready", 64'(in_ready), 64'(0));
    step(1'b1, mk(99, 99, 9, 9, 9), 1'b0, z, 1'b0, 1'b0);
    chk("refused_query", 64'(query_valid), 64'(0));
    chk("refused_level", 64'(level), 64'(8));
    step(1'b1, mk(50, 50, 5, 5, 5), 1'b1, mk(0, 1, 7, 7, 7), 1'b0, 1'b0);
    chk("full_pop_level", 64'(level), 64'(7));
    chk("full_pop_query", 64'(query_valid), 64'(0));
    step(1'b1, mk(51, 51, 5, 5, 5), 1'b1, mk(1, 2, 8, 8, 8), 1'b0, 1'b0);
    chk("pushpop_level", 64'(level), 64'(7));
    chk("pushpop_sync", 64'({sync_x, sync_y}), 64'({10'd1, 10'd2}));
    step(1'b0, z, 1'b1, mk(2, 3, 0, 0, 0), 1'b0, 1'b0);
    step(1'b0, z, 1'b1, mk(3, 4, 0, 0, 0), 1'b0, 1'b0);
    chk("pre_flush_level", 64'(level), 64'(5));
    step(1'b1, mk(77, 77, 7, 7, 7), 1'b1, mk(4, 5, 1, 1, 1), 1'b1, 1'b0);
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_query_valid", 64'(query_valid), 64'(0));
    chk("flush_level", 64'(level), 64'(0));
    step(1'b1, mk(0, 0, 1, 2, 3), 1'b0, z, 1'b0, 1'b0);
    step(1'b0, z, 1'b1, mk(0, 0, 4, 5, 6), 1'b0, 1'b0);
    chk("flush_rt_valid", 64'(out_valid), 64'(1));
    chk("flush_rt_pair", 64'({sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b}),
        64'({10'd0, 10'd0, 5'd1, 6'd2, 5'd3, 5'd4, 6'd5, 5'd6}));

    for (int k = 0; k < 3; k++) step(1'b1, mk(k + 30, k, 1, 1, 1), 1'b0, z, 1'b0, 1'b0);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(1));
    @(posedge clk_25);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic [63:0] rnd;
      ent_t ie, re;
      logic rv;
      rnd = {$urandom(), $urandom()};
      ie = rnd[35:0];
      rnd = {$urandom(), $urandom()};
      re = rnd[35:0];
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        re.x = m_q[0].x;
        re.y = m_q[0].y;
      end
      rv = $urandom_range(0, 99) < ((i % 200) < 100 ? 30 : 75);
      step(1'($urandom_range(0, 1)), ie, rv, re, $urandom_range(0, 49) == 0,
           $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
